// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Brief    : Shared pipeline constants and the IF/ID record type used by
//             the fetch and decode stages.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int               XLEN      = 32;
  localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // IF/ID pipeline record, consumed field-by-field by the decode stage
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Bubble contents: no-op word, zeroed PCs, marked invalid
  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_reg
//  Brief    : Program counter flop with reset / redirect / stall priority.
//             Also exports the PC+4 adder so IF/ID reuses the same sum.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target_aligned;

  // Sequential PC increment, wraps naturally at 2^XLEN
  assign w_pc_plus4       = r_pc + c_pc_step;
  // Misaligned targets are silently truncated to a word boundary
  assign w_target_aligned = {i_target[XLEN-1:2], 2'b00};

  // PC update: reset, then redirect (beats stall), then advance, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target_aligned;
    end else if (!i_stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction-fetch stage. Owns the PC, captures the memory word
//             with its PC and PC+4 into IF/ID, counts accepted fetches.
//             XLEN must match rv_pkg::XLEN since IF/ID uses the shared record.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int              XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  input  logic [XLEN-1:0] instr_rd,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [31:0]     fetch_cnt
);

  import rv_pkg::*;

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_capture;
  if_id_t          r_if_id;
  logic [31:0]     r_fetch_cnt;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (stall_f),
    .i_redirect (pc_src_e),
    .i_target   (pc_target_e),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // A real instruction enters IF/ID only when neither flushed nor stalled
  assign w_capture = !flush_d && !stall_d;

  // IF/ID register: reset, then flush (beats stall), then capture, else hold
  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      r_if_id <= if_id_bubble(NOP_INSTR);
    end else if (w_capture) begin
      r_if_id.instr    <= instr_rd;
      r_if_id.pc       <= w_pc;
      r_if_id.pc_plus4 <= w_pc_plus4;
      r_if_id.valid    <= 1'b1;
    end
  end

  // Accepted-fetch counter, wraps at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
    end else if (w_capture) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign pc_f       = w_pc;
  assign instr_d    = r_if_id.instr;
  assign pc_d       = r_if_id.pc;
  assign pc_plus4_d = r_if_id.pc_plus4;
  assign valid_d    = r_if_id.valid;
  assign fetch_cnt  = r_fetch_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Self-checking bench for fetch_stage: directed scenarios followed
//             by randomized control traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_nop   = 32'h0000_0013;
  localparam logic [31:0] c_rstpc = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_rd;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fetch_cnt;
  logic        valid_d;

  int tests;
  int fails;

  // Behavioural model of the architecturally visible state
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
  logic        m_valid;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .instr_rd    (instr_rd),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_cnt   (fetch_cnt)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at PC p is 0x1000_0093 + p
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0093 + a;
  endfunction

  assign instr_rd = mem_word(pc_f);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc_f",       pc_f,               m_pc);
    chk("instr_d",    instr_d,            m_instr);
    chk("pc_d",       pc_d,               m_pcd);
    chk("pc_plus4_d", pc_plus4_d,         m_pcp4);
    chk("valid_d",    {31'd0, valid_d},   {31'd0, m_valid});
    chk("fetch_cnt",  fetch_cnt,          m_cnt);
  endtask

  // One clock: apply inputs, advance model by the stage rules, check outputs
  task automatic cyc(input logic r, input logic sf, input logic sd,
                     input logic fl, input logic ps, input logic [31:0] tgt);
    logic [31:0] n_pc, n_instr, n_pcd, n_pcp4, n_cnt;
    logic        n_valid;
    reset = r; stall_f = sf; stall_d = sd; flush_d = fl;
    pc_src_e = ps; pc_target_e = tgt;

    n_pc = m_pc; n_instr = m_instr; n_pcd = m_pcd; n_pcp4 = m_pcp4;
    n_valid = m_valid; n_cnt = m_cnt;
    if (r) begin
      n_pc = c_rstpc; n_instr = c_nop; n_pcd = 0; n_pcp4 = 0; n_valid = 0; n_cnt = 0;
    end else begin
      if (ps)       n_pc = tgt & ~32'd3;
      else if (!sf) n_pc = m_pc + 32'd4;
      if (fl) begin
        n_instr = c_nop; n_pcd = 0; n_pcp4 = 0; n_valid = 0;
      end else if (!sd) begin
        n_instr = mem_word(m_pc); n_pcd = m_pc; n_pcp4 = m_pc + 32'd4;
        n_valid = 1; n_cnt = m_cnt + 32'd1;
      end
    end

    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pcp4 = n_pcp4;
    m_valid = n_valid; m_cnt = n_cnt;
    chk_all();
  endtask

  initial begin
    tests = 0; fails = 0;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0;
    reset = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    #2;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_pc",    pc_f,      32'h0);
    chk("rst_instr", instr_d,   32'h13);
    chk("rst_cnt",   fetch_cnt, 32'h0);

    // Four free-running fetches
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    chk("run_pc",    pc_f,      32'd16);
    chk("run_instr", instr_d,   32'h1000_009F);
    chk("run_cnt",   fetch_cnt, 32'd4);

    // Stall both stages at pc_f=8 for two cycles, then release
    cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 1, 1, 0, 0, 0);
    chk("stall_pc",  pc_f,      32'd8);
    chk("stall_pcd", pc_d,      32'd4);
    chk("stall_cnt", fetch_cnt, 32'd2);
    cyc(0, 0, 0, 0, 0, 0);
    chk("release_pc", pc_f, 32'd12);

    // Redirect to 0x40 with a same-cycle flush
    cyc(0, 0, 0, 1, 1, 32'h40);
    chk("redir_pc",    pc_f,            32'h40);
    chk("redir_valid", {31'd0, valid_d}, 32'd0);
    chk("redir_instr", instr_d,         32'h13);
    cyc(0, 0, 0, 0, 0, 0);
    chk("redir_pcd",   pc_d,            32'h40);
    chk("redir_vld1",  {31'd0, valid_d}, 32'd1);

    // Redirect beats stall_f; misaligned target truncated
    cyc(0, 1, 0, 0, 1, 32'h0000_0106);
    chk("align_pc", pc_f, 32'h0000_0104);

    // PC wraps from 0xFFFF_FFFC to 0
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_pc",   pc_f,       32'h0);
    chk("wrap_pcd",  pc_d,       32'hFFFF_FFFC);
    chk("wrap_pcp4", pc_plus4_d, 32'h0);

    // Reset overrides stall_d and flush_d
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    chk("rst2_pc",  pc_f,      32'h0);
    chk("rst2_cnt", fetch_cnt, 32'h0);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic r, sf, sd, fl, ps;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 49) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8 | ($urandom() & 32'h7);
      cyc(r, sf, sd, fl, ps, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_stage
`default_nettype wire
